rr_capture_arbiter: RTL

Round-robin arbiter that shares one WIDTH-bit capture register (a bank of master-slave flops) among N requesters. Each grant loads the winning requester's data into the shared register. The register then holds that value stable for HOLD_CYC cycles before another capture can happen. The block sits in front of the shared flop bank and is its only writer.

---
 rtl/rr_capture_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/rr_capture_arbiter.sv
// Round-robin arbiter that owns a shared capture register: each grant loads the
// winner's lane into q, which then stays frozen for HOLD_CYC cycles.
module rr_capture_arbiter #(
  parameter int N        = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req_i,
  input  logic [N*WIDTH-1:0]     din_i,
  output logic [N-1:0]           gnt_o,
  output logic [WIDTH-1:0]       q_o,
  output logic [$clog2(N)-1:0]   q_src_o,
  output logic                   q_vld_o,
  output logic                   busy_o
);

  localparam int PW = $clog2(N);
  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    ptr_q;
  logic [N-1:0]     gnt_q;
  logic [WIDTH-1:0] q_q;
  logic [PW-1:0]    src_q;
  logic             vld_q;

  logic [PW-1:0]    cand_idx [N];
  logic [WIDTH-1:0] lane     [N];
  logic [PW-1:0]    win_idx;
  logic             win_vld;
  logic             cap_en;
  logic [N-1:0]     gnt_d;
  logic [WIDTH-1:0] q_d;

  // cand_idx[k] is the requester examined at offset k+1 from the last winner,
  // wrapped explicitly so non-power-of-2 N goes N-1 -> 0.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [PW:0] sum;
      assign sum          = {1'b0, ptr_q} + (PW+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : sum[PW-1:0];
      assign lane[gi]     = din_i[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Scan from the far end so the nearest requesting offset overwrites last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[cand_idx[k]]) begin
        win_vld = 1'b1;
        win_idx = cand_idx[k];
      end
    end
  end

  assign cap_en = win_vld && ((state_q == ST_IDLE) || (cnt_q == '0));
  assign gnt_d  = {{(N-1){1'b0}}, 1'b1} << win_idx;
  assign q_d    = lane[win_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= PW'(N - 1);
      gnt_q   <= '0;
      q_q     <= '0;
      src_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      gnt_q <= '0;
      if (cap_en) begin
        state_q <= ST_HOLD;
        cnt_q   <= CW'(HOLD_CYC - 1);
        ptr_q   <= win_idx;
        gnt_q   <= gnt_d;
        q_q     <= q_d;
        src_q   <= win_idx;
        vld_q   <= 1'b1;
      end else if (state_q == ST_HOLD) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CW'(1);
        end else begin
          state_q <= ST_IDLE;
          vld_q   <= 1'b0;
        end
      end
    end
  end

  assign gnt_o   = gnt_q;
  assign q_o     = q_q;
  assign q_src_o = src_q;
  assign q_vld_o = vld_q;
  assign busy_o  = (state_q == ST_HOLD);

endmodule
